nap_countdown_ctrl: RTL and testbench

- Parametrised successor to the nap machine's sleep/alarm timing path: one block that holds the nap duration, counts it down, raises the alarm and handles snooze.
- Adds preset slots, BCD validation on load, limited snooze with a configurable duration, and an alarm auto-timeout.
- Sits between the keypad/setting logic (upstream) and the display mux, lullaby, alarm-sound and light blocks (downstream).

---
 rtl/nap_pkg.sv | 55 +++++
 rtl/bcd_time_dec.sv | 42 ++++
 rtl/nap_countdown_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_nap_countdown_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nap_pkg.sv
// ---------------------------------------------------------------------------
// nap_pkg
// Shared types and helpers for the nap countdown path.
//   nap_state_t    : controller state (IDLE, SLEEP, ALARM, DONE)
//   bcd_time_t     : HH:MM:SS as six BCD digits, [5]=H10 ... [0]=S1
//   BCD_ZERO       : 00:00:00
//   sec_to_bcd     : seconds -> BCD time (for elaboration constants)
//   bcd_time_valid : accepts a well-formed, non-zero time of day
// ---------------------------------------------------------------------------
package nap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SLEEP = 2'd1,
        ALARM = 2'd2,
        DONE  = 2'd3
    } nap_state_t;

    typedef logic [5:0][3:0] bcd_time_t;

    localparam bcd_time_t BCD_ZERO = 24'h000000;

    function automatic bcd_time_t sec_to_bcd(input int secs);
        int        h;
        int        m;
        int        s;
        bcd_time_t t;
        h    = secs / 3600;
        m    = (secs % 3600) / 60;
        s    = secs % 60;
        t[5] = 4'(h / 10);
        t[4] = 4'(h % 10);
        t[3] = 4'(m / 10);
        t[2] = 4'(m % 10);
        t[1] = 4'(s / 10);
        t[0] = 4'(s % 10);
        return t;
    endfunction

    function automatic logic bcd_time_valid(input bcd_time_t t);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (t[i] > 4'd9) ok = 1'b0;
        end
        if (t[5] > 4'd2) ok = 1'b0;
        if (t[3] > 4'd5) ok = 1'b0;
        if (t[1] > 4'd5) ok = 1'b0;
        // Hours 20..23 only: H1 is limited once H10 is 2.
        if (t[5] == 4'd2 && t[4] > 4'd3) ok = 1'b0;
        if (t == BCD_ZERO) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/bcd_time_dec.sv
// ---------------------------------------------------------------------------
// bcd_time_dec
// Combinational BCD HH:MM:SS minus one second.
//   t_in    : current time (BCD)
//   t_out   : t_in - 1 s, borrowing S1 -> S10 -> M1 -> M10 -> H1 -> H10
//   is_zero : t_out is 00:00:00
// A zero input is never decremented by the controller, so its wrap is
// irrelevant.
// ---------------------------------------------------------------------------
module bcd_time_dec
    import nap_pkg::*;
(
    input  bcd_time_t t_in,
    output bcd_time_t t_out,
    output logic      is_zero
);

    // Value a digit takes when it has to lend: seconds/minutes tens wrap to 5,
    // units wrap to 9. H10 never lends for a non-zero input.
    localparam bcd_time_t WRAP = {4'd0, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9};

    always_comb begin : dec_chain
        logic borrow;
        // NOTE: t_out and borrow get a value before any branch so every path
        // assigns them; otherwise this block would infer latches.
        t_out  = t_in;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (t_in[i] == 4'd0) begin
                    t_out[i] = WRAP[i];
                end else begin
                    t_out[i] = t_in[i] - 4'd1;
                    borrow   = 1'b0;
                end
            end
        end
    end

    assign is_zero = (t_out == BCD_ZERO);

endmodule

// File: rtl/nap_countdown_ctrl.sv
// ---------------------------------------------------------------------------
// nap_countdown_ctrl
// Holds the nap duration, counts it down once per second, rings the alarm,
// handles limited snoozing and auto-stops an unattended alarm.
//   clock, reset            : clock, asynchronous active-low reset
//   load / load_time        : validate and store a BCD HH:MM:SS reload value
//   preset_wr / preset_ld   : write load_time to / read reload from a slot
//   preset_sel              : slot index
//   start, snooze, dismiss, cancel : single-cycle control pulses
//   time_out                : reload (IDLE), 0 (DONE), else remaining time
//   sleeping/alarming/done  : state flags
//   missed                  : DONE was reached by alarm timeout
//   snooze_cnt              : snoozes used in the current nap
//   tick                    : one-cycle pulse per countdown second
//   load_err                : rejected load / preset access
// All outputs are registered from the next-state values.
// ---------------------------------------------------------------------------
module nap_countdown_ctrl
    import nap_pkg::*;
#(
    parameter int TICK_DIV          = 1000000,
    parameter int NUM_PRESETS       = 4,
    parameter int PSEL_W            = 2,
    parameter int SNOOZE_SEC        = 300,
    parameter int MAX_SNOOZE        = 3,
    parameter int ALARM_TIMEOUT_SEC = 60
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [23:0]       load_time,
    input  logic              preset_wr,
    input  logic              preset_ld,
    input  logic [PSEL_W-1:0] preset_sel,
    input  logic              start,
    input  logic              snooze,
    input  logic              dismiss,
    input  logic              cancel,
    output logic [23:0]       time_out,
    output logic              sleeping,
    output logic              alarming,
    output logic              done,
    output logic              missed,
    output logic [3:0]        snooze_cnt,
    output logic              tick,
    output logic              load_err
);

    localparam int               PSC_W      = $clog2(TICK_DIV);
    localparam int               AS_W       = $clog2(ALARM_TIMEOUT_SEC + 1);
    localparam logic [PSC_W-1:0] PSC_LAST   = PSC_W'(TICK_DIV - 1);
    localparam logic [AS_W-1:0]  AS_LAST    = AS_W'(ALARM_TIMEOUT_SEC - 1);
    localparam logic [3:0]       SNOOZE_MAX = 4'(MAX_SNOOZE);
    localparam bcd_time_t        SNOOZE_BCD = sec_to_bcd(SNOOZE_SEC);

    nap_state_t       state_q, state_n;
    bcd_time_t        reload_q, reload_n;
    bcd_time_t        remaining_q, remaining_n;
    bcd_time_t        presets_q [NUM_PRESETS];
    logic [PSC_W-1:0] psc_q, psc_n;
    logic [AS_W-1:0]  alarm_sec_q, alarm_sec_n;
    logic [3:0]       snz_n;
    logic             missed_n;
    logic             tick_n;
    logic             err_n;
    logic             wr_en;
    bcd_time_t        time_out_n;

    bcd_time_t        load_bcd;
    bcd_time_t        dec_out;
    logic             dec_zero;
    logic             load_ok;
    logic             sel_ok;
    logic             idle_or_done;
    logic             running_n;

    assign load_bcd     = load_time;
    assign load_ok      = bcd_time_valid(load_bcd);
    assign sel_ok       = int'(preset_sel) < NUM_PRESETS;
    assign idle_or_done = (state_q == IDLE) || (state_q == DONE);

    bcd_time_dec u_dec (
        .t_in    (remaining_q),
        .t_out   (dec_out),
        .is_zero (dec_zero)
    );

    // Next-state decision. The if/else order is the input priority; an input
    // that has no effect in the current state falls through to the next one.
    always_comb begin
        state_n     = state_q;
        reload_n    = reload_q;
        remaining_n = remaining_q;
        snz_n       = snooze_cnt;
        missed_n    = missed;
        alarm_sec_n = alarm_sec_q;
        err_n       = 1'b0;
        wr_en       = 1'b0;

        if (cancel) begin
            state_n     = IDLE;
            remaining_n = BCD_ZERO;
            snz_n       = 4'd0;
            missed_n    = 1'b0;
        end else if (dismiss && state_q == ALARM) begin
            state_n  = DONE;
            missed_n = 1'b0;
        end else if (snooze && state_q == ALARM && snooze_cnt < SNOOZE_MAX) begin
            state_n     = SLEEP;
            remaining_n = SNOOZE_BCD;
            snz_n       = snooze_cnt + 4'd1;
        end else if (start && idle_or_done && reload_q != BCD_ZERO) begin
            state_n     = SLEEP;
            remaining_n = reload_q;
            snz_n       = 4'd0;
            missed_n    = 1'b0;
        end else if (preset_ld && idle_or_done) begin
            if (sel_ok) reload_n = presets_q[preset_sel];
            else        err_n    = 1'b1;
        end else if (load && idle_or_done) begin
            if (load_ok) reload_n = load_bcd;
            else         err_n    = 1'b1;
        end else if (preset_wr && idle_or_done) begin
            if (sel_ok && load_ok) wr_en = 1'b1;
            else                   err_n = 1'b1;
        end else if (tick) begin
            // tick is high exactly in the cycle the prescaler sits at
            // TICK_DIV-1, so acting on it here consumes one second.
            if (state_q == SLEEP) begin
                remaining_n = dec_out;
                if (dec_zero) state_n = ALARM;
            end else if (state_q == ALARM) begin
                if (alarm_sec_q == AS_LAST) begin
                    state_n  = DONE;
                    missed_n = 1'b1;
                end else begin
                    alarm_sec_n = alarm_sec_q + 1'b1;
                end
            end
        end

        // Prescaler and alarm-second counter restart on every state entry.
        running_n = (state_n == SLEEP) || (state_n == ALARM);
        if (state_n != state_q || !running_n) begin
            psc_n = '0;
        end else if (psc_q == PSC_LAST) begin
            psc_n = '0;
        end else begin
            psc_n = psc_q + 1'b1;
        end
        if (state_n != state_q) alarm_sec_n = '0;
        tick_n = running_n && (psc_n == PSC_LAST);

        case (state_n)
            IDLE:    time_out_n = reload_n;
            DONE:    time_out_n = BCD_ZERO;
            default: time_out_n = remaining_n;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            reload_q    <= BCD_ZERO;
            remaining_q <= BCD_ZERO;
            psc_q       <= '0;
            alarm_sec_q <= '0;
            time_out    <= BCD_ZERO;
            sleeping    <= 1'b0;
            alarming    <= 1'b0;
            done        <= 1'b0;
            missed      <= 1'b0;
            snooze_cnt  <= 4'd0;
            tick        <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; blocking ones here would chain within the edge.
            state_q     <= state_n;
            reload_q    <= reload_n;
            remaining_q <= remaining_n;
            psc_q       <= psc_n;
            alarm_sec_q <= alarm_sec_n;
            time_out    <= time_out_n;
            sleeping    <= (state_n == SLEEP);
            alarming    <= (state_n == ALARM);
            done        <= (state_n == DONE);
            missed      <= missed_n;
            snooze_cnt  <= snz_n;
            tick        <= tick_n;
            load_err    <= err_n;
        end
    end

    // NOTE: the slots are a few flops rather than a RAM macro, and an unwritten
    // slot must read back as 00:00:00, so they take the reset like other state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PRESETS; i++) presets_q[i] <= BCD_ZERO;
        end else if (wr_en) begin
            presets_q[preset_sel] <= load_bcd;
        end
    end

endmodule

// File: tb/tb_nap_countdown_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nap_countdown_ctrl
// Directed bench for nap_countdown_ctrl. A seconds-based model (integers for
// times, cycles-in-state for the prescaler) predicts every output; a negedge
// process compares DUT against it each cycle, and literal expectations pin
// both the DUT and the model at key points.
// ---------------------------------------------------------------------------
module tb_nap_countdown_ctrl;

    localparam int TD   = 4;
    localparam int NP   = 3;
    localparam int PW   = 2;
    localparam int SNZ  = 2;
    localparam int MAXS = 1;
    localparam int ATO  = 2;

    localparam int M_IDLE  = 0;
    localparam int M_SLEEP = 1;
    localparam int M_ALARM = 2;
    localparam int M_DONE  = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          load = 1'b0;
    logic [23:0]   load_time = 24'h0;
    logic          preset_wr = 1'b0;
    logic          preset_ld = 1'b0;
    logic [PW-1:0] preset_sel = '0;
    logic          start = 1'b0;
    logic          snooze = 1'b0;
    logic          dismiss = 1'b0;
    logic          cancel = 1'b0;
    logic [23:0]   time_out;
    logic          sleeping;
    logic          alarming;
    logic          done;
    logic          missed;
    logic [3:0]    snooze_cnt;
    logic          tick;
    logic          load_err;

    int n_checks = 0;
    int n_errors = 0;

    // Model state.
    int m_mode, m_reload, m_rem, m_snz, m_missed, m_ats, m_cyc, m_err;
    int m_presets [NP];

    nap_countdown_ctrl #(
        .TICK_DIV          (TD),
        .NUM_PRESETS       (NP),
        .PSEL_W            (PW),
        .SNOOZE_SEC        (SNZ),
        .MAX_SNOOZE        (MAXS),
        .ALARM_TIMEOUT_SEC (ATO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .load_time  (load_time),
        .preset_wr  (preset_wr),
        .preset_ld  (preset_ld),
        .preset_sel (preset_sel),
        .start      (start),
        .snooze     (snooze),
        .dismiss    (dismiss),
        .cancel     (cancel),
        .time_out   (time_out),
        .sleeping   (sleeping),
        .alarming   (alarming),
        .done       (done),
        .missed     (missed),
        .snooze_cnt (snooze_cnt),
        .tick       (tick),
        .load_err   (load_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Seconds of a BCD time, or -1 if it is not a valid time of day.
    function automatic int bcd_secs(input logic [23:0] v);
        int d [6];
        int h, m, s;
        for (int i = 0; i < 6; i++) begin
            d[i] = int'(v[4*i +: 4]);
            if (d[i] > 9) return -1;
        end
        h = d[5] * 10 + d[4];
        m = d[3] * 10 + d[2];
        s = d[1] * 10 + d[0];
        if (h > 23 || m > 59 || s > 59) return -1;
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic logic [23:0] to_bcd(input int secs);
        int h, m, s;
        h = secs / 3600;
        m = (secs / 60) % 60;
        s = secs % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [23:0] exp_time();
        if (m_mode == M_IDLE) return to_bcd(m_reload);
        if (m_mode == M_DONE) return 24'h0;
        return to_bcd(m_rem);
    endfunction

    function automatic logic exp_tick();
        return (m_mode == M_SLEEP || m_mode == M_ALARM) && (m_cyc % TD == TD - 1);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_reload = 0; m_rem = 0; m_snz = 0;
        m_missed = 0; m_ats = 0; m_cyc = 0; m_err = 0;
        for (int i = 0; i < NP; i++) m_presets[i] = 0;
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_step();
        int  prev, v, sel;
        bit  ticked, idle_done;
        ticked    = exp_tick();
        prev      = m_mode;
        m_err     = 0;
        sel       = int'(preset_sel);
        v         = bcd_secs(load_time);
        idle_done = (m_mode == M_IDLE || m_mode == M_DONE);
        if (cancel) begin
            m_mode = M_IDLE; m_rem = 0; m_snz = 0; m_missed = 0;
        end else if (dismiss && m_mode == M_ALARM) begin
            m_mode = M_DONE; m_missed = 0;
        end else if (snooze && m_mode == M_ALARM && m_snz < MAXS) begin
            m_mode = M_SLEEP; m_rem = SNZ; m_snz++;
        end else if (start && idle_done && m_reload != 0) begin
            m_mode = M_SLEEP; m_rem = m_reload; m_snz = 0; m_missed = 0;
        end else if (preset_ld && idle_done) begin
            if (sel < NP) m_reload = m_presets[sel];
            else          m_err = 1;
        end else if (load && idle_done) begin
            if (v > 0) m_reload = v;
            else       m_err = 1;
        end else if (preset_wr && idle_done) begin
            if (sel < NP && v > 0) m_presets[sel] = v;
            else                   m_err = 1;
        end else if (ticked) begin
            if (m_mode == M_SLEEP) begin
                m_rem--;
                if (m_rem == 0) m_mode = M_ALARM;
            end else begin
                m_ats++;
                if (m_ats == ATO) begin
                    m_mode = M_DONE; m_missed = 1;
                end
            end
        end
        if (m_mode != prev) begin
            m_cyc = 0; m_ats = 0;
        end else begin
            m_cyc++;
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (reset) begin
            check("cmp_time_out", 32'(time_out), 32'(exp_time()));
            check("cmp_sleeping", 32'(sleeping), 32'(m_mode == M_SLEEP));
            check("cmp_alarming", 32'(alarming), 32'(m_mode == M_ALARM));
            check("cmp_done", 32'(done), 32'(m_mode == M_DONE));
            check("cmp_missed", 32'(missed), 32'(m_missed));
            check("cmp_snooze_cnt", 32'(snooze_cnt), 32'(m_snz));
            check("cmp_tick", 32'(tick), 32'(exp_tick()));
            check("cmp_load_err", 32'(load_err), 32'(m_err));
        end
    end

    task automatic clear_pulses();
        load = 1'b0; preset_wr = 1'b0; preset_ld = 1'b0; start = 1'b0;
        snooze = 1'b0; dismiss = 1'b0; cancel = 1'b0;
    endtask

    // Advance n edges; pulses set before the call last exactly one edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            model_step();
            #1;
            clear_pulses();
        end
    endtask

    // Literal pin: f = {sleeping, alarming, done, missed}.
    task automatic pin(input string name, input logic [23:0] t, input logic [3:0] f);
        check({name, "_time"}, 32'(time_out), 32'(t));
        check({name, "_flags"}, 32'({sleeping, alarming, done, missed}), 32'(f));
        check({name, "_model"}, 32'(exp_time()), 32'(t));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #1 reset = 1'b0;
        #2;
        pin("reset", 24'h000000, 4'b0000);
        check("reset_snz", 32'(snooze_cnt), 32'(0));
        @(negedge clock);
        reset = 1'b1;

        // 1: three-second nap.
        load_time = 24'h000003; load = 1'b1; cyc(1);
        pin("t1_load", 24'h000003, 4'b0000);
        start = 1'b1; cyc(1);
        pin("t1_start", 24'h000003, 4'b1000);
        cyc(3);
        check("t1_tick", 32'(tick), 32'(1));
        cyc(1);
        pin("t1_2s", 24'h000002, 4'b1000);
        cyc(4);
        pin("t1_1s", 24'h000001, 4'b1000);
        cyc(3);
        pin("t1_last_tick", 24'h000001, 4'b1000);
        cyc(1);
        pin("t1_alarm", 24'h000000, 4'b0100);

        // 4: alarm times out after two seconds.
        cyc(7);
        pin("t4_ringing", 24'h000000, 4'b0100);
        cyc(1);
        pin("t4_missed", 24'h000000, 4'b0011);
        start = 1'b1; cyc(1);
        pin("t4_restart", 24'h000003, 4'b1000);
        check("t4_snz", 32'(snooze_cnt), 32'(0));

        // 3: one snooze allowed, then dismiss.
        cyc(12);
        pin("t3_alarm1", 24'h000000, 4'b0100);
        snooze = 1'b1; cyc(1);
        pin("t3_snoozed", 24'h000002, 4'b1000);
        check("t3_snz1", 32'(snooze_cnt), 32'(1));
        cyc(8);
        pin("t3_alarm2", 24'h000000, 4'b0100);
        snooze = 1'b1; cyc(1);
        pin("t3_snz_ignored", 24'h000000, 4'b0100);
        dismiss = 1'b1; cyc(1);
        pin("t3_dismiss", 24'h000000, 4'b0010);

        // 2: rejected loads keep reload; hour borrow.
        load_time = 24'h005960; load = 1'b1; cyc(1);
        check("t2_err_s10", 32'(load_err), 32'(1));
        cyc(1);
        check("t2_err_clear", 32'(load_err), 32'(0));
        load_time = 24'h240000; load = 1'b1; cyc(1);
        check("t2_err_h24", 32'(load_err), 32'(1));
        load_time = 24'h000000; load = 1'b1; cyc(1);
        check("t2_err_zero", 32'(load_err), 32'(1));
        cancel = 1'b1; cyc(1);
        pin("t2_kept", 24'h000003, 4'b0000);
        load_time = 24'h010000; load = 1'b1; cyc(1);
        start = 1'b1; cyc(1);
        load_time = 24'h000007; load = 1'b1; cyc(1);
        check("t2_load_in_sleep", 32'(load_err), 32'(0));
        cyc(3);
        pin("t2_borrow", 24'h005959, 4'b1000);
        cancel = 1'b1; cyc(1);
        pin("t2_cancel", 24'h010000, 4'b0000);

        // 5: presets.
        preset_sel = 2'd2; load_time = 24'h001000; preset_wr = 1'b1; cyc(1);
        pin("t5_wr", 24'h010000, 4'b0000);
        load_time = 24'h000005; load = 1'b1; cyc(1);
        pin("t5_load", 24'h000005, 4'b0000);
        preset_sel = 2'd2; preset_ld = 1'b1; cyc(1);
        pin("t5_ld", 24'h001000, 4'b0000);
        preset_sel = 2'd3; preset_wr = 1'b1; cyc(1);
        check("t5_bad_wr", 32'(load_err), 32'(1));
        preset_sel = 2'd3; preset_ld = 1'b1; cyc(1);
        check("t5_bad_ld", 32'(load_err), 32'(1));
        pin("t5_kept", 24'h001000, 4'b0000);

        // 6: cancel beats snooze; asynchronous reset mid-sleep.
        load_time = 24'h000001; load = 1'b1; cyc(1);
        start = 1'b1; cyc(1);
        cyc(4);
        pin("t6_alarm", 24'h000000, 4'b0100);
        cancel = 1'b1; snooze = 1'b1; cyc(1);
        pin("t6_cancel", 24'h000001, 4'b0000);
        check("t6_snz", 32'(snooze_cnt), 32'(0));
        start = 1'b1; cyc(1);
        cyc(2);
        #2 reset = 1'b0;
        #1;
        model_reset();
        pin("t6_reset", 24'h000000, 4'b0000);
        check("t6_reset_misc", 32'({snooze_cnt, tick, load_err}), 32'(0));
        @(negedge clock);
        reset = 1'b1;
        start = 1'b1; cyc(1);
        pin("t6_start_zero", 24'h000000, 4'b0000);

        // Boundaries: largest valid time, and a ten-hour borrow.
        load_time = 24'h235959; load = 1'b1; cyc(1);
        pin("bnd_max", 24'h235959, 4'b0000);
        load_time = 24'h100000; load = 1'b1; cyc(1);
        start = 1'b1; cyc(1);
        cyc(4);
        pin("bnd_h10", 24'h095959, 4'b1000);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
